// File: rtl/cache_arbiter.sv
// Two-requester arbiter sharing one line-wide memory port between I-cache and D-cache.
// Round-robin on ties, with an IDLE cycle between transactions and latched request fields.
module cache_arbiter #(
    parameter int s_line = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_read,
    input  logic [31:0]       i_address,
    output logic [s_line-1:0] i_rdata,
    output logic              i_resp,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [31:0]       d_address,
    input  logic [s_line-1:0] d_wdata,
    output logic [s_line-1:0] d_rdata,
    output logic              d_resp,
    output logic [31:0]       pmem_address,
    output logic [s_line-1:0] pmem_wdata,
    output logic              pmem_read,
    output logic              pmem_write,
    input  logic [s_line-1:0] pmem_rdata,
    input  logic              pmem_resp
);
    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] GRANT_I = 2'd1;
    localparam logic [1:0] GRANT_D = 2'd2;

    logic [1:0]        state;
    logic [31:0]       addr_q;
    logic [s_line-1:0] wdata_q;
    logic              write_q;
    logic              last_d;
    logic              d_req;
    logic              grant_d;
    logic              grant_i;
    logic              busy;

    assign d_req   = d_read | d_write;
    // D wins a tie unless it was the one served most recently.
    assign grant_d = d_req & (~i_read | ~last_d);
    assign grant_i = i_read & ~grant_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            write_q <= 1'b0;
            last_d  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_d) begin
                        state   <= GRANT_D;
                        addr_q  <= d_address;
                        wdata_q <= d_wdata;
                        write_q <= d_write;
                        last_d  <= 1'b1;
                    end else if (grant_i) begin
                        state   <= GRANT_I;
                        addr_q  <= i_address;
                        write_q <= 1'b0;
                        last_d  <= 1'b0;
                    end
                end
                GRANT_I, GRANT_D: begin
                    // Completion always returns to IDLE, which forces a strobe-low gap.
                    if (pmem_resp) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy         = (state == GRANT_I) || (state == GRANT_D);
    assign pmem_address = busy ? addr_q : '0;
    assign pmem_wdata   = busy ? wdata_q : '0;
    assign pmem_read    = busy & ~write_q;
    assign pmem_write   = busy & write_q;

    assign i_resp  = (state == GRANT_I) & pmem_resp;
    assign d_resp  = (state == GRANT_D) & pmem_resp;
    assign i_rdata = i_resp ? pmem_rdata : '0;
    assign d_rdata = (d_resp & ~write_q) ? pmem_rdata : '0;
endmodule

// File: tb/tb_cache_arbiter.sv
// Bench for cache_arbiter: directed vector table, hand-written reset/latching sequences,
// then random traffic scored against a transaction-level ownership model.
module tb_cache_arbiter;
    logic         clk = 1'b0;
    logic         rst;
    logic         i_read, d_read, d_write, pmem_resp;
    logic [31:0]  i_address, d_address, pmem_address;
    logic [255:0] d_wdata, pmem_rdata;
    logic [255:0] i_rdata, d_rdata, pmem_wdata;
    logic         i_resp, d_resp, pmem_read, pmem_write;

    int checks = 0;
    int failures = 0;

    localparam logic [255:0] PAT_A5 = {32{8'hA5}};
    localparam logic [255:0] PAT_5A = {32{8'h5A}};

    cache_arbiter #(.s_line(256)) dut (
        .clk(clk), .rst(rst),
        .i_read(i_read), .i_address(i_address), .i_rdata(i_rdata), .i_resp(i_resp),
        .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_resp(d_resp),
        .pmem_address(pmem_address), .pmem_wdata(pmem_wdata), .pmem_read(pmem_read),
        .pmem_write(pmem_write), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rs, ir, dr, dw, pr;
        logic        er, ew;
        logic [31:0] ea;
        logic        eir, edr;
    } vec_t;

    vec_t tbl[26];

    function automatic vec_t mk(logic rs, logic ir, logic dr, logic dw, logic pr,
                                logic er, logic ew, logic [31:0] ea, logic eir, logic edr);
        vec_t v;
        v.rs = rs; v.ir = ir; v.dr = dr; v.dw = dw; v.pr = pr;
        v.er = er; v.ew = ew; v.ea = ea; v.eir = eir; v.edr = edr;
        return v;
    endfunction

    function automatic logic [255:0] rand256();
        logic [255:0] r;
        for (int k = 0; k < 8; k++) r[k*32 +: 32] = $urandom();
        return r;
    endfunction

    task automatic check(input string nm, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_ctrl(input string nm, input logic er, input logic ew,
                              input logic [31:0] ea, input logic eir, input logic edr);
        check(nm, {220'd0, pmem_read, pmem_write, pmem_address, i_resp, d_resp},
                  {220'd0, er, ew, ea, eir, edr});
    endtask

    task automatic do_reset();
        rst = 1'b1;
        i_read = 0; d_read = 0; d_write = 0; pmem_resp = 0;
        i_address = '0; d_address = '0; d_wdata = '0; pmem_rdata = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // Transaction-level reference: who owns the port and which request it is serving.
    int           m_owner;   // 0 none, 1 I, 2 D
    logic         m_last_i;
    logic [31:0]  m_addr;
    logic         m_wr;
    logic [255:0] m_wdata;

    task automatic run_random(input int ncyc);
        logic take_d, want_i, want_d, strobe;
        logic         er, ew, eir, edr;
        logic [31:0]  ea;
        m_owner = 0; m_last_i = 1'b1; m_addr = '0; m_wr = 0; m_wdata = '0;
        for (int c = 0; c < ncyc; c++) begin
            @(posedge clk);
            want_i = i_read;
            want_d = d_read | d_write;
            if (m_owner != 0) begin
                if (pmem_resp) m_owner = 0;
            end else if (want_i || want_d) begin
                take_d = want_d && (!want_i || m_last_i);
                if (take_d) begin
                    m_owner = 2; m_addr = d_address; m_wr = d_write; m_wdata = d_wdata; m_last_i = 0;
                end else begin
                    m_owner = 1; m_addr = i_address; m_wr = 0; m_last_i = 1;
                end
            end
            #1;
            strobe = pmem_read | pmem_write;
            pmem_resp  = strobe ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 9) == 0);
            pmem_rdata = rand256();
            if (!i_read && $urandom_range(0, 3) == 0) begin
                i_read = 1; i_address = $urandom() & 32'hFFFF_FFE0;
            end
            if (!(d_read || d_write) && $urandom_range(0, 3) == 0) begin
                case ($urandom_range(0, 2))
                    0: begin d_read = 1; d_write = 0; end
                    1: begin d_read = 0; d_write = 1; end
                    default: begin d_read = 1; d_write = 1; end
                endcase
                d_address = $urandom() & 32'hFFFF_FFE0;
                d_wdata = rand256();
            end
            #1;
            er  = (m_owner != 0) && !m_wr;
            ew  = (m_owner != 0) && m_wr;
            ea  = (m_owner != 0) ? m_addr : 32'd0;
            eir = (m_owner == 1) && pmem_resp;
            edr = (m_owner == 2) && pmem_resp;
            check_ctrl("rand_ctrl", er, ew, ea, eir, edr);
            check("rand_i_rdata", i_rdata, eir ? pmem_rdata : 256'd0);
            check("rand_d_rdata", d_rdata, (edr && !m_wr) ? pmem_rdata : 256'd0);
            if (ew) check("rand_wdata", pmem_wdata, m_wdata);
            if (m_owner == 0) check("rand_idle_wdata", pmem_wdata, 256'd0);
            if (i_resp) i_read = 0;
            if (d_resp) begin d_read = 0; d_write = 0; end
        end
    endtask

    initial begin
        //            rs ir dr dw pr   er ew ea            eir edr
        tbl[0]  = mk(0, 1, 0, 0, 0,   0, 0, 32'h0,        0, 0);
        tbl[1]  = mk(0, 1, 0, 0, 0,   1, 0, 32'h1000,     0, 0);
        tbl[2]  = mk(0, 1, 0, 0, 0,   1, 0, 32'h1000,     0, 0);
        tbl[3]  = mk(0, 1, 0, 0, 0,   1, 0, 32'h1000,     0, 0);
        tbl[4]  = mk(0, 1, 0, 0, 0,   1, 0, 32'h1000,     0, 0);
        tbl[5]  = mk(0, 0, 0, 0, 1,   1, 0, 32'h1000,     1, 0);
        tbl[6]  = mk(0, 0, 0, 0, 1,   0, 0, 32'h0,        0, 0);
        tbl[7]  = mk(0, 0, 0, 1, 0,   0, 0, 32'h0,        0, 0);
        tbl[8]  = mk(0, 0, 0, 1, 0,   0, 1, 32'h2020,     0, 0);
        tbl[9]  = mk(0, 0, 0, 0, 1,   0, 1, 32'h2020,     0, 1);
        tbl[10] = mk(0, 0, 0, 0, 0,   0, 0, 32'h0,        0, 0);
        tbl[11] = mk(1, 0, 0, 0, 0,   0, 0, 32'h0,        0, 0);
        tbl[12] = mk(0, 1, 1, 0, 0,   0, 0, 32'h0,        0, 0);
        tbl[13] = mk(0, 1, 1, 0, 0,   1, 0, 32'h2020,     0, 0);
        tbl[14] = mk(0, 1, 0, 0, 1,   1, 0, 32'h2020,     0, 1);
        tbl[15] = mk(0, 1, 0, 0, 0,   0, 0, 32'h0,        0, 0);
        tbl[16] = mk(0, 1, 0, 0, 0,   1, 0, 32'h1000,     0, 0);
        tbl[17] = mk(0, 0, 0, 0, 1,   1, 0, 32'h1000,     1, 0);
        tbl[18] = mk(0, 1, 1, 0, 0,   0, 0, 32'h0,        0, 0);
        tbl[19] = mk(0, 1, 1, 0, 0,   1, 0, 32'h2020,     0, 0);
        tbl[20] = mk(0, 1, 0, 0, 1,   1, 0, 32'h2020,     0, 1);
        tbl[21] = mk(0, 0, 0, 0, 0,   0, 0, 32'h0,        0, 0);
        tbl[22] = mk(0, 0, 1, 1, 0,   0, 0, 32'h0,        0, 0);
        tbl[23] = mk(0, 0, 1, 1, 0,   0, 1, 32'h2020,     0, 0);
        tbl[24] = mk(0, 0, 0, 0, 1,   0, 1, 32'h2020,     0, 1);
        tbl[25] = mk(0, 0, 0, 0, 0,   0, 0, 32'h0,        0, 0);

        do_reset();
        #1;
        check_ctrl("reset_ctrl", 0, 0, 32'h0, 0, 0);
        check("reset_wdata", pmem_wdata, 256'd0);
        check("reset_rdata", {i_rdata ^ d_rdata}, 256'd0);

        i_address = 32'h0000_1000; d_address = 32'h0000_2020;
        d_wdata = PAT_5A; pmem_rdata = PAT_A5;
        for (int r = 0; r < 26; r++) begin
            tick();
            rst = tbl[r].rs; i_read = tbl[r].ir; d_read = tbl[r].dr;
            d_write = tbl[r].dw; pmem_resp = tbl[r].pr;
            #1;
            check_ctrl($sformatf("vec%0d_ctrl", r), tbl[r].er, tbl[r].ew, tbl[r].ea,
                       tbl[r].eir, tbl[r].edr);
            check($sformatf("vec%0d_i_rdata", r), i_rdata, tbl[r].eir ? PAT_A5 : 256'd0);
            check($sformatf("vec%0d_d_rdata", r), d_rdata,
                  (tbl[r].edr && !tbl[r].ew) ? PAT_A5 : 256'd0);
            if (tbl[r].ew) check($sformatf("vec%0d_wdata", r), pmem_wdata, PAT_5A);
        end

        // Asynchronous reset between edges while a read is in flight.
        tick(); i_read = 1; i_address = 32'h0000_3000; pmem_resp = 0;
        tick(); #1;
        check_ctrl("pre_rst_grant", 1, 0, 32'h3000, 0, 0);
        #1 rst = 1; i_read = 0; pmem_resp = 1;
        #1;
        check_ctrl("async_rst_drop", 0, 0, 32'h0, 0, 0);
        tick(); rst = 0;
        for (int k = 0; k < 3; k++) begin
            tick(); #1;
            check_ctrl($sformatf("post_rst_resp%0d", k), 0, 0, 32'h0, 0, 0);
        end
        pmem_resp = 0;

        // Latched address survives requester changes; dropped request still completes once.
        tick(); d_read = 1; d_address = 32'h0000_2020;
        tick(); d_address = 32'hFFFF_FFE0; d_read = 0; #1;
        check_ctrl("latch_hold0", 1, 0, 32'h2020, 0, 0);
        tick(); #1;
        check_ctrl("latch_hold1", 1, 0, 32'h2020, 0, 0);
        tick(); pmem_resp = 1; pmem_rdata = PAT_A5; #1;
        check_ctrl("drop_complete", 1, 0, 32'h2020, 0, 1);
        check("drop_rdata", d_rdata, PAT_A5);
        tick(); pmem_resp = 0; #1;
        check_ctrl("drop_idle", 0, 0, 32'h0, 0, 0);

        do_reset();
        run_random(3000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/cache_arbiter.md
CACHE_ARBITER -- requirements
Module: cache_arbiter

Interface
REQ-001 Parameter: s_line, 256, cache line width in bits on both requester and memory sides.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 i_read  input  1  instruction-cache line read request.
REQ-005 i_address  input  32  instruction-cache line address.
REQ-006 i_rdata  output  s_line  line returned to instruction cache.
REQ-007 i_resp  output  1  instruction-cache transaction complete.
REQ-008 d_read  input  1  data-cache line read request.
REQ-009 d_write  input  1  data-cache line write-back request.
REQ-010 d_address  input  32  data-cache line address.
REQ-011 d_wdata  input  s_line  data-cache write-back line.
REQ-012 d_rdata  output  s_line  line returned to data cache.
REQ-013 d_resp  output  1  data-cache transaction complete.
REQ-014 pmem_address  output  32  shared memory line address.
REQ-015 pmem_wdata  output  s_line  shared memory write line.
REQ-016 pmem_read  output  1  shared memory read strobe.
REQ-017 pmem_write  output  1  shared memory write strobe.
REQ-018 pmem_rdata  input  s_line  shared memory read line.
REQ-019 pmem_resp  input  1  shared memory transaction complete.

Function
REQ-020 FSM states: IDLE, GRANT_I, GRANT_D; exactly one owner of the memory port at any time.
REQ-021 IDLE: pmem_read=0, pmem_write=0, i_resp=0, d_resp=0, pmem_address=0, pmem_wdata=0.
REQ-022 IDLE with only i_read: next state GRANT_I; latch i_address, set latched op=read.
REQ-023 IDLE with only d_read or d_write: next state GRANT_D; latch d_address, d_wdata, op=write if d_write else read.
REQ-024 d_read and d_write both asserted: treated as write; d_read ignored for that transaction.
REQ-025 Simultaneous I and D requests in IDLE: round-robin; grant goes to requester not served last; 1-bit last_served register updated on each grant.
REQ-026 GRANT_x: pmem_address/pmem_wdata driven from latched registers; pmem_read or pmem_write (per latched op) held high every cycle until pmem_resp.
REQ-027 Request-to-strobe latency: 1 cycle (request sampled in IDLE at edge N, strobe high from cycle N+1).
REQ-028 On pmem_resp in GRANT_I: i_resp=1 and i_rdata=pmem_rdata combinationally that cycle; next state IDLE.
REQ-029 On pmem_resp in GRANT_D: d_resp=1, d_rdata=pmem_rdata (read) same cycle; next state IDLE.
REQ-030 Non-owner resp stays 0; i_rdata/d_rdata are 0 whenever the corresponding resp is 0.
REQ-031 Mandatory IDLE cycle after each completion: pmem strobes low at least one cycle between transactions.
REQ-032 Requester dropping its request mid-grant: transaction still completes; resp pulses once, then IDLE.
REQ-033 Changes on requester address/wdata during grant do not affect pmem outputs (latched values used).
REQ-034 pmem_resp in IDLE is ignored; no resp generated, state unchanged.
REQ-035 Waiting requester is served immediately after the current transaction's IDLE cycle; no starvation beyond one transaction.

Reset
REQ-036 rst high asynchronously forces IDLE, clears latched address/wdata/op, sets last_served=I (D wins first tie).
REQ-037 rst mid-transaction drops pmem_read/pmem_write and all resp outputs in the same cycle, without waiting for a clock edge; an in-flight pmem_resp after reset is ignored.

Verification
REQ-038 Bench: i_read, i_address=0x0000_1000 alone; pmem_resp after 5 cycles with rdata=0xA5.. -> pmem_read high cycles 1-5, address 0x1000, i_resp one cycle with i_rdata=0xA5.., d_resp=0.
REQ-039 Bench: d_write, d_address=0x0000_2020, d_wdata=0x5A.. -> pmem_write high, pmem_wdata=0x5A.., d_resp one cycle, pmem_read never high.
REQ-040 Bench: i_read and d_read raised same cycle after reset -> D served first, one IDLE cycle, then I served; next tie afterward grants D (alternation).
REQ-041 Bench: during GRANT_D change d_address to 0xFFFF_FFE0 -> pmem_address stays original latched value until d_resp.
REQ-042 Bench: assert rst between clock edges while pmem_read high -> pmem_read=0 immediately; subsequent pmem_resp produces no i_resp/d_resp.
REQ-043 Bench: d_read and d_write both high -> pmem_write only; pmem_resp while IDLE -> no response outputs.
